// File: rtl/uart_rx_line_buffer.sv
// Line buffer behind uart_rx: collects bytes up to a terminator, then streams the line out.
// Optional LINE_EDIT_EN: BS (08h) / DEL (7Fh) erase the last stored byte while filling.
module uart_rx_line_buffer #(
  parameter int          DEPTH       = 64,
  parameter logic [7:0]  TERM_CHAR   = 8'h0A,
  parameter logic [7:0]  IGNORE_CHAR = 8'h0D,
  parameter int          LW          = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready,
  output logic [LW-1:0] line_len,
  output logic          line_trunc,
  output logic [7:0]    drop_count,
  output logic          busy
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [LW-1:0] ONE     = LW'(1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          rx_ready_q;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic          trunc_q, trunc_d;
  logic [7:0]    drop_q, drop_d;
  logic [7:0]    mem_q [DEPTH];
  logic          mem_we;
  logic          rx_event;
  logic          is_edit;

  assign rx_event = rx_ready & ~rx_ready_q;

`ifdef LINE_EDIT_EN
  assign is_edit = (rx_data == 8'h08) || (rx_data == 8'h7F);
`else
  assign is_edit = 1'b0;
`endif

  assign out_valid  = (state_q == DRAIN);
  assign busy       = out_valid;
  assign out_data   = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
  assign out_last   = out_valid && (rd_ptr_q == (len_q - ONE));
  assign line_len   = len_q;
  assign line_trunc = trunc_q;
  assign drop_count = drop_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rd_ptr_d = rd_ptr_q;
    trunc_d  = trunc_q;
    drop_d   = drop_q;
    mem_we   = 1'b0;
    case (state_q)
      FILL: begin
        if (rx_event) begin
          if (rx_data == TERM_CHAR) begin
            // An empty line produces no stream at all.
            if (len_q != '0) begin
              state_d  = DRAIN;
              rd_ptr_d = '0;
            end
          end else if (rx_data == IGNORE_CHAR) begin
            state_d = FILL;
          end else if (is_edit) begin
            if (len_q != '0) len_d = len_q - ONE;
          end else if (len_q < DEPTH_L) begin
            mem_we = 1'b1;
            len_d  = len_q + ONE;
          end else begin
            trunc_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (out_last) begin
            state_d  = FILL;
            len_d    = '0;
            rd_ptr_d = '0;
            trunc_d  = 1'b0;
          end else begin
            rd_ptr_d = rd_ptr_q + ONE;
          end
        end
        // Bytes arriving mid-drain are lost; only their count survives.
        if (rx_event && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      rx_ready_q <= 1'b1;
      len_q      <= '0;
      rd_ptr_q   <= '0;
      trunc_q    <= 1'b0;
      drop_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready;
      len_q      <= len_d;
      rd_ptr_q   <= rd_ptr_d;
      trunc_q    <= trunc_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[len_q[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_line_buffer.sv
// Randomized self-checking bench for uart_rx_line_buffer against a queue-based line model.
module tb_uart_rx_line_buffer;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready = 1'b0;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_last;
  logic [LW-1:0] line_len;
  logic          line_trunc;
  logic [7:0]    drop_count;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the line as a queue, plus truncation, drain and drop state.
  logic [7:0] line_q[$];
  bit         m_trunc = 0;
  bit         m_draining = 0;
  int         m_drops = 0;

  uart_rx_line_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .line_len(line_len), .line_trunc(line_trunc),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_feed(input logic [7:0] b);
    if (m_draining) begin
      if (m_drops < 255) m_drops++;
    end else if (b == 8'h0A) begin
      if (line_q.size() > 0) m_draining = 1;
    end else if (b == 8'h0D) begin
      m_draining = 0;
`ifdef LINE_EDIT_EN
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (line_q.size() > 0) void'(line_q.pop_back());
`endif
    end else if (line_q.size() < DEPTH) begin
      line_q.push_back(b);
    end else begin
      m_trunc = 1;
    end
  endtask

  // Called and returns at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_data  = b;
    rx_ready = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rx_ready = 1'b0;
    model_feed(b);
    @(posedge clk); #1;
  endtask

  task automatic send_str(input string s, input int hold);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], hold);
  endtask

  // Drains the expected line with out_ready asserted ready_pct percent of cycles.
  task automatic do_drain(input int ready_pct, output int cycles);
    int n = line_q.size();
    int idx = 0;
    logic [13+LW-1:0] got, exp;
    cycles = 0;
    while (idx < n && cycles < 300) begin
      out_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      got = {out_valid, busy, out_data, out_last, line_len, line_trunc};
      exp = {1'b1, 1'b1, line_q[idx], (idx == n - 1), LW'(n), m_trunc};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL drain_byte idx=%0d got v/b/d/l/len/t=%h required %h", idx, got, exp);
      end
      if (out_ready && out_valid) begin
        $display("xfer idx=%0d data=%02h last=%0b", idx, out_data, out_last);
        idx++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    out_ready = 1'b0;
    vectors++;
    if (idx != n) begin
      miscompares++;
      $display("FAIL drain_timeout transferred=%0d required %0d", idx, n);
    end
    line_q.delete();
    m_trunc = 0;
    m_draining = 0;
    @(negedge clk);
    vectors++;
    if ({out_valid, busy, line_len, line_trunc, drop_count} !== {1'b0, 1'b0, LW'(0), 1'b0, 8'(m_drops)}) begin
      miscompares++;
      $display("FAIL drain_end got v=%0b b=%0b len=%0d t=%0b drops=%0d required 0 0 0 0 %0d",
               out_valid, busy, line_len, line_trunc, drop_count, m_drops);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    int cyc;
    rx_data  = 8'h7A;
    rx_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({out_valid, out_last, busy, out_data, line_len, line_trunc, drop_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got v=%0b l=%0b b=%0b d=%02h len=%0d t=%0b drops=%0d required all 0",
               out_valid, out_last, busy, out_data, line_len, line_trunc, drop_count);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (line_len !== LW'(0) || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_level_no_event got len=%0d v=%0b required 0 0", line_len, out_valid);
    end
    @(posedge clk); #1 rx_ready = 1'b0;
    @(posedge clk); #1;
    $display("reset done");
    cyc = 0;
  endtask

  task automatic test_basic;
    int cyc;
    send_str("ab\n", 100);
    @(negedge clk);
    vectors++;
    if (line_len !== LW'(2) || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_len got len=%0d v=%0b required 2 1", line_len, out_valid);
    end
    @(posedge clk); #1;
    do_drain(100, cyc);
  endtask

  task automatic test_hold;
    int cyc;
    rx_data  = "x";
    rx_ready = 1'b1;
    repeat (1000) @(posedge clk);
    #1 rx_ready = 1'b0;
    model_feed("x");
    @(negedge clk);
    vectors++;
    if (line_len !== LW'(1)) begin
      miscompares++;
      $display("FAIL hold_single_event got len=%0d required 1", line_len);
    end
    @(posedge clk); #1;
    send_str("\n", 2);
    do_drain(70, cyc);
  endtask

  task automatic test_trunc;
    int cyc;
    send_str("abcdef\n", 1);
    @(negedge clk);
    vectors++;
    if (line_trunc !== 1'b1 || line_len !== LW'(DEPTH)) begin
      miscompares++;
      $display("FAIL trunc_flag got t=%0b len=%0d required 1 %0d", line_trunc, line_len, DEPTH);
    end
    @(posedge clk); #1;
    do_drain(60, cyc);
  endtask

  task automatic test_drop;
    send_str("q\n", 3);
    out_ready = 1'b0;
    send_byte("r", 2);
    send_byte("s", 1);
    send_byte(8'h0A, 4);
    @(negedge clk);
    vectors++;
    if ({drop_count, out_valid, out_data, out_last} !== {8'(m_drops), 1'b1, 8'h71, 1'b1}) begin
      miscompares++;
      $display("FAIL drop_hold got drops=%0d v=%0b d=%02h l=%0b required %0d 1 71 1",
               drop_count, out_valid, out_data, out_last, m_drops);
    end
    @(posedge clk); #1;
    // Byte arriving in the same cycle as the final transfer is also dropped.
    rx_data = "z"; rx_ready = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0; out_ready = 1'b0;
    $display("xfer idx=0 data=71 last=1");
    m_drops++;
    line_q.delete(); m_draining = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({out_valid, line_len, drop_count} !== {1'b0, LW'(0), 8'(m_drops)}) begin
      miscompares++;
      $display("FAIL drop_final_cycle got v=%0b len=%0d drops=%0d required 0 0 %0d",
               out_valid, line_len, drop_count, m_drops);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore;
    int cyc;
    send_byte(8'h0D, 2);
    send_byte(8'h0A, 2);
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || line_len !== LW'(0)) begin
        miscompares++;
        $display("FAIL empty_line got v=%0b len=%0d required 0 0", out_valid, line_len);
      end
    end
    @(posedge clk); #1;
    send_byte("a", 1);
    send_byte(8'h0D, 1);
    send_byte(8'h0A, 1);
    do_drain(100, cyc);
  endtask

  task automatic test_edit;
    int cyc;
    send_str("ab", 1);
    send_byte(8'h08, 1);
    send_str("c\n", 1);
    @(negedge clk);
    vectors++;
`ifdef LINE_EDIT_EN
    if (line_len !== LW'(2)) begin
`else
    if (line_len !== LW'(4)) begin
`endif
      miscompares++;
      $display("FAIL edit_len got len=%0d", line_len);
    end
    @(posedge clk); #1;
    do_drain(80, cyc);
  endtask

  task automatic test_back_to_back;
    int cyc;
    send_str("wxyz\n", 1);
    do_drain(100, cyc);
    vectors++;
    if (cyc != 4) begin
      miscompares++;
      $display("FAIL back_to_back got cycles=%0d required 4", cyc);
    end
  endtask

  task automatic test_random;
    int cyc, n, r;
    logic [7:0] b;
    for (int line = 0; line < 20; line++) begin
      n = $urandom_range(0, 7);
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(99);
        if (r < 10)      b = 8'h0D;
        else if (r < 20) b = 8'h08;
        else if (r < 25) b = 8'h7F;
        else             b = 8'(8'h61 + $urandom_range(25));
        send_byte(b, $urandom_range(1, 4));
      end
      send_byte(8'h0A, $urandom_range(1, 3));
      if (m_draining) begin
        do_drain($urandom_range(30, 100), cyc);
      end else begin
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || line_len !== LW'(0)) begin
          miscompares++;
          $display("FAIL rand_empty got v=%0b len=%0d required 0 0", out_valid, line_len);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid_drain;
    int cyc;
    send_str("kk\n", 1);
    out_ready = 1'b0;
    send_byte("y", 1);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, busy, out_data, line_len, drop_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_drain got v=%0b b=%0b d=%02h len=%0d drops=%0d required all 0",
               out_valid, busy, out_data, line_len, drop_count);
    end
    line_q.delete(); m_trunc = 0; m_draining = 0; m_drops = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_str("x\n", 2);
    do_drain(100, cyc);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_trunc();
    test_drop();
    test_ignore();
    test_edit();
    test_back_to_back();
    test_random();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
